// File: rtl/rob_param_pkg.sv
// Shared defaults, instruction-class flags and FSM encoding for the reorder buffer.
package rob_param_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_NAME_W = 5;
  localparam int unsigned ROB_DATA_W = 32;
  localparam int unsigned ROB_ADDR_W = 32;

  localparam logic STORE = 1'b1;
  localparam logic JUMP  = 1'b1;

  typedef enum logic {
    RUN        = 1'b0,
    STORE_WAIT = 1'b1
  } rob_state_e;

  // A resolved branch whose actual direction differs from the prediction.
  function automatic logic is_mispredict(input logic branch, input logic pd, input logic ac);
    return (branch == JUMP) && (pd != ac);
  endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer plus nick<->index mapping.
module rob_ptr_ctrl
  import rob_param_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned IDX_W = $clog2(DEPTH),
  parameter int unsigned TAG_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic             retire,
  input  logic             flush,
  input  logic [TAG_W-1:0] ex_nick,
  input  logic [TAG_W-1:0] slb_nick,
  output logic [IDX_W-1:0] head,
  output logic [IDX_W-1:0] tail,
  output logic [IDX_W-1:0] ex_idx_c,
  output logic [IDX_W-1:0] slb_idx_c,
  output logic [TAG_W-1:0] head_nick_c,
  output logic [TAG_W-1:0] tail_nick_c,
  output logic             ex_tag_ok_c,
  output logic             slb_tag_ok_c,
  output logic             full_c
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [CNT_W-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (alloc)  tail <= tail + IDX_W'(1);
      if (retire) head <= head + IDX_W'(1);
      case ({alloc, retire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign full_c = (count_q == CNT_W'(DEPTH));

  // Nick 0 means "no tag"; nick n names entry n-1.
  assign head_nick_c  = TAG_W'(head) + TAG_W'(1);
  assign tail_nick_c  = TAG_W'(tail) + TAG_W'(1);
  assign ex_idx_c     = IDX_W'(ex_nick - TAG_W'(1));
  assign slb_idx_c    = IDX_W'(slb_nick - TAG_W'(1));
  assign ex_tag_ok_c  = (ex_nick != '0) && (ex_nick <= TAG_W'(DEPTH));
  assign slb_tag_ok_c = (slb_nick != '0) && (slb_nick <= TAG_W'(DEPTH));

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate/retire, out-of-order writeback,
// store-commit handshake and branch-mispredict flush.
module rob_param
  import rob_param_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned IDX_W  = $clog2(DEPTH),
  parameter int unsigned TAG_W  = IDX_W + 1,
  parameter int unsigned NAME_W = ROB_NAME_W,
  parameter int unsigned DATA_W = ROB_DATA_W,
  parameter int unsigned ADDR_W = ROB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              oINF_full,
  input  logic              iIND_en,
  input  logic [NAME_W-1:0] iIND_rd_regnm,
  input  logic              iIND_store,
  input  logic              iIND_branch,
  input  logic              iIND_pd,
  output logic              oROB_nick_en,
  output logic [TAG_W-1:0]  oROB_nick,
  input  logic              iEX_en,
  input  logic [TAG_W-1:0]  iEX_nick,
  input  logic [DATA_W-1:0] iEX_dt,
  input  logic              iEX_ac,
  input  logic [ADDR_W-1:0] iEX_j_pc,
  input  logic              iSLB_en,
  input  logic [TAG_W-1:0]  iSLB_nick,
  input  logic [DATA_W-1:0] iSLB_dt,
  output logic              oSLB_store_en,
  output logic [TAG_W-1:0]  oSLB_store_nick,
  input  logic              iSLB_store_done,
  output logic              oRF_en,
  output logic [NAME_W-1:0] oRF_rd_regnm,
  output logic [DATA_W-1:0] oRF_rd_dt,
  output logic [TAG_W-1:0]  oRF_rd_nick,
  output logic              clr,
  output logic [ADDR_W-1:0] oINF_j_pc
);

  rob_state_e state_q, state_n;

  logic [IDX_W-1:0] head, tail, ex_idx, slb_idx;
  logic [TAG_W-1:0] head_nick, tail_nick;
  logic             ex_tag_ok, slb_tag_ok, full;
  logic             alloc, retire, flush, ex_wb, slb_wb;

  logic [DEPTH-1:0]  valid_q, ready_q, store_q, branch_q, pd_q, ac_q;
  logic [NAME_W-1:0] regnm_q [DEPTH];
  logic [DATA_W-1:0] dt_q    [DEPTH];
  logic [ADDR_W-1:0] j_pc_q  [DEPTH];

  logic              head_valid, head_ready, head_store, head_branch, head_pd, head_ac;
  logic [NAME_W-1:0] head_regnm;
  logic [DATA_W-1:0] head_dt;
  logic [ADDR_W-1:0] head_j_pc;

  logic              rf_en_n, st_en_n, clr_n;
  logic [NAME_W-1:0] rf_regnm_n;
  logic [DATA_W-1:0] rf_dt_n;
  logic [TAG_W-1:0]  rf_nick_n, st_nick_n;
  logic [ADDR_W-1:0] j_pc_n;

  rob_ptr_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_ptr (
    .clk          (clk),
    .rst          (rst),
    .alloc        (alloc),
    .retire       (retire),
    .flush        (flush),
    .ex_nick      (iEX_nick),
    .slb_nick     (iSLB_nick),
    .head         (head),
    .tail         (tail),
    .ex_idx_c     (ex_idx),
    .slb_idx_c    (slb_idx),
    .head_nick_c  (head_nick),
    .tail_nick_c  (tail_nick),
    .ex_tag_ok_c  (ex_tag_ok),
    .slb_tag_ok_c (slb_tag_ok),
    .full_c       (full)
  );

  // Dispatch-side handshake; the flush cycle looks full to decode.
  assign oINF_full    = full || clr;
  assign oROB_nick_en = iIND_en && !oINF_full && rdy;
  assign oROB_nick    = oROB_nick_en ? tail_nick : '0;
  assign alloc        = oROB_nick_en;

  assign ex_wb  = rdy && !clr && iEX_en  && ex_tag_ok  && valid_q[ex_idx];
  assign slb_wb = rdy && !clr && iSLB_en && slb_tag_ok && valid_q[slb_idx];

  assign head_valid  = valid_q[head];
  assign head_ready  = ready_q[head];
  assign head_store  = store_q[head];
  assign head_branch = branch_q[head];
  assign head_pd     = pd_q[head];
  assign head_ac     = ac_q[head];
  assign head_regnm  = regnm_q[head];
  assign head_dt     = dt_q[head];
  assign head_j_pc   = j_pc_q[head];

  // Entry status bits; flush empties the whole buffer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      ready_q <= '0;
    end else begin
      if (alloc) begin
        valid_q[tail] <= 1'b1;
        ready_q[tail] <= 1'b0;
      end
      if (slb_wb) ready_q[slb_idx] <= 1'b1;
      if (ex_wb)  ready_q[ex_idx]  <= 1'b1;
      if (retire) begin
        valid_q[head] <= 1'b0;
        ready_q[head] <= 1'b0;
      end
    end
  end

  // Entry payload; EX is written last so it wins a same-tag collision with SLB.
  always_ff @(posedge clk) begin
    if (alloc) begin
      regnm_q[tail]  <= iIND_rd_regnm;
      store_q[tail]  <= iIND_store;
      branch_q[tail] <= iIND_branch;
      pd_q[tail]     <= iIND_pd;
      ac_q[tail]     <= 1'b0;
    end
    if (slb_wb) dt_q[slb_idx] <= iSLB_dt;
    if (ex_wb) begin
      dt_q[ex_idx]   <= iEX_dt;
      ac_q[ex_idx]   <= iEX_ac;
      j_pc_q[ex_idx] <= iEX_j_pc;
    end
  end

  // Retire FSM: next state and next registered outputs.
  always_comb begin
    state_n    = state_q;
    retire     = 1'b0;
    flush      = 1'b0;
    rf_en_n    = 1'b0;
    rf_regnm_n = oRF_rd_regnm;
    rf_dt_n    = oRF_rd_dt;
    rf_nick_n  = oRF_rd_nick;
    st_en_n    = 1'b0;
    st_nick_n  = oSLB_store_nick;
    clr_n      = 1'b0;
    j_pc_n     = oINF_j_pc;
    if (rdy && !clr) begin
      case (state_q)
        RUN: begin
          if (head_valid) begin
            if (head_store == STORE) begin
              st_en_n   = 1'b1;
              st_nick_n = head_nick;
              state_n   = STORE_WAIT;
            end else if (head_ready) begin
              rf_en_n    = (head_regnm != '0);
              rf_regnm_n = head_regnm;
              rf_dt_n    = head_dt;
              rf_nick_n  = head_nick;
              if (is_mispredict(head_branch, head_pd, head_ac)) begin
                flush  = 1'b1;
                clr_n  = 1'b1;
                j_pc_n = head_j_pc;
              end else begin
                retire = 1'b1;
              end
            end
          end
        end
        STORE_WAIT: begin
          if (iSLB_store_done) begin
            retire  = 1'b1;
            state_n = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      oRF_en          <= 1'b0;
      oRF_rd_regnm    <= '0;
      oRF_rd_dt       <= '0;
      oRF_rd_nick     <= '0;
      oSLB_store_en   <= 1'b0;
      oSLB_store_nick <= '0;
      clr             <= 1'b0;
      oINF_j_pc       <= '0;
    end else begin
      state_q         <= state_n;
      oRF_en          <= rf_en_n;
      oRF_rd_regnm    <= rf_regnm_n;
      oRF_rd_dt       <= rf_dt_n;
      oRF_rd_nick     <= rf_nick_n;
      oSLB_store_en   <= st_en_n;
      oSLB_store_nick <= st_nick_n;
      clr             <= clr_n;
      oINF_j_pc       <= j_pc_n;
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Directed self-checking bench for rob_param (default parameters).
module tb_rob_param;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        oINF_full;
  logic        iIND_en, iIND_store, iIND_branch, iIND_pd;
  logic [4:0]  iIND_rd_regnm;
  logic        oROB_nick_en;
  logic [4:0]  oROB_nick;
  logic        iEX_en, iEX_ac;
  logic [4:0]  iEX_nick;
  logic [31:0] iEX_dt, iEX_j_pc;
  logic        iSLB_en;
  logic [4:0]  iSLB_nick;
  logic [31:0] iSLB_dt;
  logic        oSLB_store_en;
  logic [4:0]  oSLB_store_nick;
  logic        iSLB_store_done;
  logic        oRF_en;
  logic [4:0]  oRF_rd_regnm;
  logic [31:0] oRF_rd_dt;
  logic [4:0]  oRF_rd_nick;
  logic        clr;
  logic [31:0] oINF_j_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rob_param dut (
    .clk (clk), .rst (rst), .rdy (rdy), .oINF_full (oINF_full),
    .iIND_en (iIND_en), .iIND_rd_regnm (iIND_rd_regnm), .iIND_store (iIND_store),
    .iIND_branch (iIND_branch), .iIND_pd (iIND_pd),
    .oROB_nick_en (oROB_nick_en), .oROB_nick (oROB_nick),
    .iEX_en (iEX_en), .iEX_nick (iEX_nick), .iEX_dt (iEX_dt), .iEX_ac (iEX_ac),
    .iEX_j_pc (iEX_j_pc),
    .iSLB_en (iSLB_en), .iSLB_nick (iSLB_nick), .iSLB_dt (iSLB_dt),
    .oSLB_store_en (oSLB_store_en), .oSLB_store_nick (oSLB_store_nick),
    .iSLB_store_done (iSLB_store_done),
    .oRF_en (oRF_en), .oRF_rd_regnm (oRF_rd_regnm), .oRF_rd_dt (oRF_rd_dt),
    .oRF_rd_nick (oRF_rd_nick), .clr (clr), .oINF_j_pc (oINF_j_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; iIND_en = 1'b0; iIND_rd_regnm = '0; iIND_store = 1'b0;
    iIND_branch = 1'b0; iIND_pd = 1'b0; iEX_en = 1'b0; iEX_nick = '0; iEX_dt = '0;
    iEX_ac = 1'b0; iEX_j_pc = '0; iSLB_en = 1'b0; iSLB_nick = '0; iSLB_dt = '0;
    iSLB_store_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] regnm, input logic st, input logic br, input logic pd);
    iIND_en = 1'b1; iIND_rd_regnm = regnm; iIND_store = st; iIND_branch = br; iIND_pd = pd;
    step();
    iIND_en = 1'b0; iIND_store = 1'b0; iIND_branch = 1'b0; iIND_pd = 1'b0;
  endtask

  task automatic ex_wb(input logic [4:0] nick, input logic [31:0] dt, input logic ac,
                       input logic [31:0] jpc);
    iEX_en = 1'b1; iEX_nick = nick; iEX_dt = dt; iEX_ac = ac; iEX_j_pc = jpc;
    step();
    iEX_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (oRF_en !== 1'b0) begin errors++; $display("FAIL reset_rf_en got=%0h exp=0", oRF_en); end
    checks++; if (clr !== 1'b0) begin errors++; $display("FAIL reset_clr got=%0h exp=0", clr); end
    checks++; if (oSLB_store_en !== 1'b0) begin errors++; $display("FAIL reset_store_en got=%0h exp=0", oSLB_store_en); end
    checks++; if (oINF_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0h exp=0", oINF_full); end
    checks++; if (oINF_j_pc !== 32'h0) begin errors++; $display("FAIL reset_j_pc got=%0h exp=0", oINF_j_pc); end
    checks++; if (oROB_nick !== 5'd0) begin errors++; $display("FAIL reset_nick_idle got=%0h exp=0", oROB_nick); end
    iIND_en = 1'b1;
    #1;
    checks++; if (oROB_nick !== 5'd1 || oROB_nick_en !== 1'b1) begin errors++; $display("FAIL reset_first_nick got=%0h en=%0h exp=1 en=1", oROB_nick, oROB_nick_en); end
    iIND_en = 1'b0;
  endtask

  task automatic test_in_order();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      iIND_en = 1'b1; iIND_rd_regnm = 5'(i);
      #1;
      checks++; if (oROB_nick !== 5'(i)) begin errors++; $display("FAIL inorder_nick%0d got=%0h exp=%0h", i, oROB_nick, i); end
      step();
    end
    iIND_en = 1'b0;
    ex_wb(5'd3, 32'h30, 1'b0, 32'h0);
    ex_wb(5'd1, 32'h10, 1'b0, 32'h0);
    ex_wb(5'd2, 32'h20, 1'b0, 32'h0);
    checks++; if (oRF_en !== 1'b1 || oRF_rd_regnm !== 5'd1 || oRF_rd_dt !== 32'h10 || oRF_rd_nick !== 5'd1)
      begin errors++; $display("FAIL inorder_commit1 got en=%0h rn=%0h dt=%0h nk=%0h exp 1/1/10/1", oRF_en, oRF_rd_regnm, oRF_rd_dt, oRF_rd_nick); end
    step();
    checks++; if (oRF_en !== 1'b1 || oRF_rd_regnm !== 5'd2 || oRF_rd_dt !== 32'h20 || oRF_rd_nick !== 5'd2)
      begin errors++; $display("FAIL inorder_commit2 got en=%0h rn=%0h dt=%0h nk=%0h exp 1/2/20/2", oRF_en, oRF_rd_regnm, oRF_rd_dt, oRF_rd_nick); end
    step();
    checks++; if (oRF_en !== 1'b1 || oRF_rd_regnm !== 5'd3 || oRF_rd_dt !== 32'h30 || oRF_rd_nick !== 5'd3)
      begin errors++; $display("FAIL inorder_commit3 got en=%0h rn=%0h dt=%0h nk=%0h exp 1/3/30/3", oRF_en, oRF_rd_regnm, oRF_rd_dt, oRF_rd_nick); end
    step();
    checks++; if (oRF_en !== 1'b0) begin errors++; $display("FAIL inorder_idle got=%0h exp=0", oRF_en); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      iIND_en = 1'b1; iIND_rd_regnm = 5'(i + 1);
      #1;
      checks++; if (oROB_nick !== 5'(i + 1)) begin errors++; $display("FAIL full_fill_nick%0d got=%0h exp=%0h", i + 1, oROB_nick, i + 1); end
      step();
    end
    #1;
    checks++; if (oINF_full !== 1'b1) begin errors++; $display("FAIL full_flag got=%0h exp=1", oINF_full); end
    checks++; if (oROB_nick_en !== 1'b0 || oROB_nick !== 5'd0) begin errors++; $display("FAIL full_17th got en=%0h nick=%0h exp 0/0", oROB_nick_en, oROB_nick); end
    ex_wb(5'd1, 32'hAA, 1'b0, 32'h0);
    #1;
    checks++; if (oROB_nick_en !== 1'b0) begin errors++; $display("FAIL full_retire_cycle_alloc got=%0h exp=0", oROB_nick_en); end
    step();
    #1;
    checks++; if (oRF_en !== 1'b1 || oRF_rd_nick !== 5'd1) begin errors++; $display("FAIL full_retire got en=%0h nick=%0h exp 1/1", oRF_en, oRF_rd_nick); end
    checks++; if (oROB_nick_en !== 1'b1 || oROB_nick !== 5'd1) begin errors++; $display("FAIL full_wrap_nick got en=%0h nick=%0h exp 1/1", oROB_nick_en, oROB_nick); end
    step();
    iIND_en = 1'b0;
    #1;
    checks++; if (oINF_full !== 1'b1) begin errors++; $display("FAIL full_refill got=%0h exp=1", oINF_full); end
  endtask

  task automatic test_store();
    do_reset();
    alloc(5'd5, 1'b1, 1'b0, 1'b0);
    alloc(5'd9, 1'b0, 1'b0, 1'b0);
    checks++; if (oSLB_store_en !== 1'b1 || oSLB_store_nick !== 5'd1) begin errors++; $display("FAIL store_pulse got en=%0h nick=%0h exp 1/1", oSLB_store_en, oSLB_store_nick); end
    ex_wb(5'd2, 32'h22, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (oSLB_store_en !== 1'b0 || oRF_en !== 1'b0) begin errors++; $display("FAIL store_hold%0d got st=%0h rf=%0h exp 0/0", i, oSLB_store_en, oRF_en); end
      if (i < 3) step();
    end
    iSLB_store_done = 1'b1;
    step();
    iSLB_store_done = 1'b0;
    checks++; if (oRF_en !== 1'b0) begin errors++; $display("FAIL store_retire_rf got=%0h exp=0", oRF_en); end
    step();
    checks++; if (oRF_en !== 1'b1 || oRF_rd_regnm !== 5'd9 || oRF_rd_dt !== 32'h22 || oRF_rd_nick !== 5'd2)
      begin errors++; $display("FAIL store_next_commit got en=%0h rn=%0h dt=%0h nk=%0h exp 1/9/22/2", oRF_en, oRF_rd_regnm, oRF_rd_dt, oRF_rd_nick); end
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc(5'd1, 1'b0, 1'b1, 1'b0);
    for (int k = 2; k <= 6; k++) alloc(5'(k), 1'b0, 1'b0, 1'b0);
    ex_wb(5'd1, 32'h44, 1'b1, 32'h1000);
    step();
    checks++; if (clr !== 1'b1 || oINF_j_pc !== 32'h1000) begin errors++; $display("FAIL mp_clr got clr=%0h pc=%0h exp 1/1000", clr, oINF_j_pc); end
    checks++; if (oRF_en !== 1'b1 || oRF_rd_regnm !== 5'd1 || oRF_rd_dt !== 32'h44) begin errors++; $display("FAIL mp_link got en=%0h rn=%0h dt=%0h exp 1/1/44", oRF_en, oRF_rd_regnm, oRF_rd_dt); end
    iIND_en = 1'b1; iIND_rd_regnm = 5'd7;
    #1;
    checks++; if (oINF_full !== 1'b1 || oROB_nick_en !== 1'b0 || oROB_nick !== 5'd0) begin errors++; $display("FAIL mp_clr_alloc got full=%0h en=%0h nick=%0h exp 1/0/0", oINF_full, oROB_nick_en, oROB_nick); end
    step();
    checks++; if (clr !== 1'b0 || oRF_en !== 1'b0) begin errors++; $display("FAIL mp_clr_end got clr=%0h rf=%0h exp 0/0", clr, oRF_en); end
    checks++; if (oINF_full !== 1'b0 || oROB_nick_en !== 1'b1 || oROB_nick !== 5'd1) begin errors++; $display("FAIL mp_realloc got full=%0h en=%0h nick=%0h exp 0/1/1", oINF_full, oROB_nick_en, oROB_nick); end
    step();
    iIND_en = 1'b0;
    ex_wb(5'd1, 32'h77, 1'b0, 32'h0);
    step();
    checks++; if (oRF_en !== 1'b1 || oRF_rd_regnm !== 5'd7 || oRF_rd_dt !== 32'h77 || oRF_rd_nick !== 5'd1)
      begin errors++; $display("FAIL mp_after_commit got en=%0h rn=%0h dt=%0h nk=%0h exp 1/7/77/1", oRF_en, oRF_rd_regnm, oRF_rd_dt, oRF_rd_nick); end
  endtask

  task automatic test_regnm0_stray();
    do_reset();
    ex_wb(5'd7, 32'hDEAD, 1'b0, 32'h0);
    step();
    checks++; if (oRF_en !== 1'b0) begin errors++; $display("FAIL stray_wb got=%0h exp=0", oRF_en); end
    alloc(5'd0, 1'b0, 1'b0, 1'b0);
    alloc(5'd4, 1'b0, 1'b0, 1'b0);
    ex_wb(5'd1, 32'h11, 1'b0, 32'h0);
    ex_wb(5'd2, 32'h22, 1'b0, 32'h0);
    checks++; if (oRF_en !== 1'b0) begin errors++; $display("FAIL r0_no_write got=%0h exp=0", oRF_en); end
    step();
    checks++; if (oRF_en !== 1'b1 || oRF_rd_regnm !== 5'd4 || oRF_rd_dt !== 32'h22 || oRF_rd_nick !== 5'd2)
      begin errors++; $display("FAIL r0_head_advanced got en=%0h rn=%0h dt=%0h nk=%0h exp 1/4/22/2", oRF_en, oRF_rd_regnm, oRF_rd_dt, oRF_rd_nick); end
  endtask

  task automatic test_rdy();
    do_reset();
    alloc(5'd2, 1'b0, 1'b0, 1'b0);
    ex_wb(5'd1, 32'h5, 1'b0, 32'h0);
    rdy = 1'b0; iIND_en = 1'b1;
    #1;
    checks++; if (oROB_nick_en !== 1'b0) begin errors++; $display("FAIL rdy_alloc got=%0h exp=0", oROB_nick_en); end
    step();
    checks++; if (oRF_en !== 1'b0) begin errors++; $display("FAIL rdy_hold got=%0h exp=0", oRF_en); end
    rdy = 1'b1; iIND_en = 1'b0;
    step();
    checks++; if (oRF_en !== 1'b1 || oRF_rd_dt !== 32'h5) begin errors++; $display("FAIL rdy_resume got en=%0h dt=%0h exp 1/5", oRF_en, oRF_rd_dt); end
  endtask

  task automatic test_rst_store_wait();
    do_reset();
    alloc(5'd3, 1'b0, 1'b0, 1'b0);
    ex_wb(5'd1, 32'h33, 1'b0, 32'h0);
    step();
    alloc(5'd0, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if (oSLB_store_en !== 1'b1 || oSLB_store_nick !== 5'd2) begin errors++; $display("FAIL rsw_pulse got en=%0h nick=%0h exp 1/2", oSLB_store_en, oSLB_store_nick); end
    rst = 1'b1;
    step();
    checks++; if (oRF_en !== 1'b0 || oRF_rd_regnm !== 5'd0 || oRF_rd_dt !== 32'h0 || oRF_rd_nick !== 5'd0)
      begin errors++; $display("FAIL rsw_rf_zero got en=%0h rn=%0h dt=%0h nk=%0h exp 0/0/0/0", oRF_en, oRF_rd_regnm, oRF_rd_dt, oRF_rd_nick); end
    checks++; if (oSLB_store_en !== 1'b0 || oSLB_store_nick !== 5'd0 || clr !== 1'b0) begin errors++; $display("FAIL rsw_misc_zero got st=%0h nk=%0h clr=%0h exp 0/0/0", oSLB_store_en, oSLB_store_nick, clr); end
    rst = 1'b0;
    iIND_en = 1'b1; iIND_rd_regnm = 5'd6;
    #1;
    checks++; if (oROB_nick !== 5'd1) begin errors++; $display("FAIL rsw_first_nick got=%0h exp=1", oROB_nick); end
    step();
    iIND_en = 1'b0;
    ex_wb(5'd1, 32'h66, 1'b0, 32'h0);
    step();
    checks++; if (oRF_en !== 1'b1 || oRF_rd_regnm !== 5'd6 || oRF_rd_dt !== 32'h66) begin errors++; $display("FAIL rsw_run_commit got en=%0h rn=%0h dt=%0h exp 1/6/66", oRF_en, oRF_rd_regnm, oRF_rd_dt); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_in_order();
    test_full();
    test_store();
    test_mispredict();
    test_regnm0_stray();
    test_rdy();
    test_rst_store_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
